mac_accumulator: RTL and testbench



---
 rtl/mac_accumulator_pkg.sv | 19 +
 rtl/fx_sm_convert.sv | 27 ++
 rtl/mac_accumulator.sv | 118 +++++++++++
 tb/tb_mac_accumulator.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_accumulator_pkg.sv
// Shared Q7.8 sign-magnitude fixed-point constants and the accumulator FSM state type.
// The multiply unit upstream uses the same constants.
package mac_accumulator_pkg;

  localparam int FX_FRAC     = 8;
  localparam int FX_SIGN_BIT = 15;
  localparam int FX_MAG_W    = 15;
  localparam logic [FX_MAG_W-1:0] FX_MAX_MAG = 15'h7FFF;

  localparam int SM_W  = FX_SIGN_BIT + 1;  // sign-magnitude word width
  localparam int ACC_W = 17;                // two's-complement accumulator width

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DONE
  } state_e;

endpackage

// File: rtl/fx_sm_convert.sv
// Combinational sign-magnitude <-> two's-complement conversion.
// The to-sign-magnitude path clamps the magnitude to FX_MAX_MAG and flags it.
module fx_sm_convert
  import mac_accumulator_pkg::*;
(
  input  logic [SM_W-1:0]  sm_in,
  output logic [ACC_W-1:0] tc_out,
  input  logic [ACC_W:0]   tc_in,    // one guard bit so an unclamped sum fits
  output logic [SM_W-1:0]  sm_out,
  output logic             clamped
);

  logic [ACC_W-1:0] mag_ext;
  logic [ACC_W:0]   tc_abs;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    mag_ext = {2'b00, sm_in[FX_MAG_W-1:0]};
    // A negative zero (0x8000) negates to 0, so it never produces a distinct code.
    tc_out  = sm_in[FX_SIGN_BIT] ? ('0 - mag_ext) : mag_ext;

    tc_abs  = tc_in[ACC_W] ? ('0 - tc_in) : tc_in;
    clamped = (tc_abs > {3'b000, FX_MAX_MAG});
    sm_out  = {tc_in[ACC_W], (clamped ? FX_MAX_MAG : tc_abs[FX_MAG_W-1:0])};
  end

endmodule

// File: rtl/mac_accumulator.sv
// Saturating accumulator for a stream of sign-magnitude Q7.8 products; emits one
// sign-magnitude Q7.8 result with zero/neg/overflow flags per programmed reduction.
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     prod,
  input  logic             prod_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     acc,
  output logic             zero,
  output logic             neg,
  output logic             overflow,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [ACC_W-1:0] prod_tc;
  logic [ACC_W:0]   sum_raw;
  logic [SM_W-1:0]  sum_sat_sm;
  logic             sum_clamped;
  logic [ACC_W-1:0] sum_sat_tc;
  logic [SM_W-1:0]  acc_sm;
  logic             out_clamped;

  // Input side: product to two's complement, and clamp of the widened raw sum.
  fx_sm_convert u_conv_in (
    .sm_in   (prod[SM_W-1:0]),
    .tc_out  (prod_tc),
    .tc_in   (sum_raw),
    .sm_out  (sum_sat_sm),
    .clamped (sum_clamped)
  );

  // Output side: clamped sum back to two's complement for the register, and the
  // registered sum to sign-magnitude for acc.
  fx_sm_convert u_conv_out (
    .sm_in   (sum_sat_sm),
    .tc_out  (sum_sat_tc),
    .tc_in   ({sum_q[ACC_W-1], sum_q}),
    .sm_out  (acc_sm),
    .clamped (out_clamped)
  );

  assign sum_raw = {sum_q[ACC_W-1], sum_q} + {prod_tc[ACC_W-1], prod_tc};

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    count_d   = count_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sum_d   = '0;
          ovf_d   = 1'b0;
          count_d = len;
          state_d = (len != '0) ? ST_ACCUM : ST_DONE;
        end
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sum_d   = sum_sat_tc;
          ovf_d   = ovf_q | sum_clamped | prod_cout;
          count_d = count_q - 1'b1;
          if (count_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign acc      = {{(N-SM_W){1'b0}}, acc_sm};
  assign zero     = (sum_q == '0);
  assign neg      = acc_sm[FX_SIGN_BIT];
  assign overflow = ovf_q;
  assign busy     = (state_q != ST_IDLE);

  // The stored sum is always within +/-FX_MAX_MAG, so the output path never clamps.
  a_out_no_clamp: assert property (@(posedge clk) disable iff (!rst_n) !out_clamped);

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: a behavioural model pushes the expected result
// when a reduction's stimulus is driven, and it is popped when out_valid appears.
module tb_mac_accumulator;

  typedef struct packed {
    logic [31:0] acc;
    logic        zero;
    logic        neg;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] prod;
  logic        prod_cout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] acc;
  logic        zero;
  logic        neg;
  logic        overflow;
  logic        busy;

  int   n_tests;
  int   n_fail;
  exp_t sb[$];
  int   m_sum;
  bit   m_ovf;

  mac_accumulator #(.N(32), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .prod_cout (prod_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .zero      (zero),
    .neg       (neg),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_start();
    m_sum = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_beat(input logic [15:0] p, input logic c);
    int v;
    v = int'(p[14:0]);
    if (p[15]) v = -v;
    m_sum = m_sum + v;
    if (m_sum > 32767) begin
      m_sum = 32767;
      m_ovf = 1'b1;
    end else if (m_sum < -32767) begin
      m_sum = -32767;
      m_ovf = 1'b1;
    end
    if (c) m_ovf = 1'b1;
  endtask

  task automatic model_push();
    exp_t e;
    int   mag;
    mag    = (m_sum < 0) ? -m_sum : m_sum;
    e.acc  = {16'h0000, (m_sum < 0), 15'(mag)};
    e.zero = (m_sum == 0);
    e.neg  = (m_sum < 0);
    e.ovf  = m_ovf;
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  // Offers one product for one cycle; upper prod bits carry junk that must be ignored.
  task automatic drive_beat(input logic [15:0] p, input logic c);
    logic [15:0] junk;
    junk      = 16'($urandom());
    in_valid  = 1'b1;
    prod      = {junk, p};
    prod_cout = c;
    model_beat(p, c);
    tick();
    in_valid  = 1'b0;
    prod_cout = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_reduction(input logic [15:0] ps[4], input int n);
    model_start();
    do_start(8'(n));
    for (int i = 0; i < n; i++) drive_beat(ps[i], 1'b0);
    model_push();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; len = '0; in_valid = 1'b0; prod = '0; prod_cout = 1'b0; out_ready = 1'b0;
    #3;
    n_tests++;
    if ({in_ready, out_valid, busy, acc, neg, overflow, zero} !== {3'b000, 32'h0, 3'b001}) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b ov=%b busy=%b acc=%h neg=%b ovf=%b zero=%b, want 0 0 0 00000000 0 0 1",
               in_ready, out_valid, busy, acc, neg, overflow, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    bit   ok;
    exp_t e;
    logic [15:0] ps[3];
    ps = '{16'h0180, 16'h0200, 16'h8080};
    model_start();
    do_start(8'd3);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_in_ready beat %0d: got %b want 1", i, in_ready);
      end
      drive_beat(ps[i], 1'b0);
    end
    model_push();
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_latency: out_valid=%b the cycle after last beat, want 1", out_valid);
    end
    wait_out(ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || {acc, zero, neg, overflow} !== e) begin
      n_fail++;
      $display("FAIL b2b_result: got acc=%h z=%b n=%b ovf=%b (valid=%b), want acc=%h z=%b n=%b ovf=%b",
               acc, zero, neg, overflow, ok, e.acc, e.zero, e.neg, e.ovf);
    end
    finish_out();
    n_tests++;
    if ({out_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_return_idle: got out_valid=%b busy=%b, want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_saturation();
    bit   ok;
    exp_t e;
    run_reduction('{16'h4000, 16'h4000, 16'h0000, 16'h0000}, 2);
    wait_out(ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || {acc, zero, neg, overflow} !== e) begin
      n_fail++;
      $display("FAIL sat_pos: got acc=%h z=%b n=%b ovf=%b (valid=%b), want acc=%h z=%b n=%b ovf=%b",
               acc, zero, neg, overflow, ok, e.acc, e.zero, e.neg, e.ovf);
    end
    finish_out();
    run_reduction('{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000}, 2);
    wait_out(ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || {acc, zero, neg, overflow} !== e) begin
      n_fail++;
      $display("FAIL sat_neg: got acc=%h z=%b n=%b ovf=%b (valid=%b), want acc=%h z=%b n=%b ovf=%b",
               acc, zero, neg, overflow, ok, e.acc, e.zero, e.neg, e.ovf);
    end
    finish_out();
  endtask

  task automatic test_zero_result();
    bit   ok;
    exp_t e;
    run_reduction('{16'h0100, 16'h8100, 16'h0000, 16'h0000}, 2);
    wait_out(ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || {acc, zero, neg, overflow} !== e) begin
      n_fail++;
      $display("FAIL zero_cancel: got acc=%h z=%b n=%b ovf=%b (valid=%b), want acc=%h z=%b n=%b ovf=%b",
               acc, zero, neg, overflow, ok, e.acc, e.zero, e.neg, e.ovf);
    end
    finish_out();
    run_reduction('{16'h8000, 16'h0000, 16'h0000, 16'h0000}, 1);
    wait_out(ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || {acc, zero, neg, overflow} !== e) begin
      n_fail++;
      $display("FAIL zero_negzero: got acc=%h z=%b n=%b ovf=%b (valid=%b), want acc=%h z=%b n=%b ovf=%b",
               acc, zero, neg, overflow, ok, e.acc, e.zero, e.neg, e.ovf);
    end
    finish_out();
  endtask

  task automatic test_len_zero();
    exp_t e;
    model_start();
    model_push();
    start = 1'b1;
    len   = 8'd0;
    in_valid = 1'b1;
    tick();
    start = 1'b0;
    e = sb.pop_front();
    n_tests++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL len0_latency: got out_valid=%b in_ready=%b, want 1 0", out_valid, in_ready);
    end
    n_tests++;
    if ({acc, zero, neg, overflow} !== e) begin
      n_fail++;
      $display("FAIL len0_result: got acc=%h z=%b n=%b ovf=%b, want acc=%h z=%b n=%b ovf=%b",
               acc, zero, neg, overflow, e.acc, e.zero, e.neg, e.ovf);
    end
    finish_out();
    in_valid = 1'b0;
  endtask

  task automatic test_stall_hold();
    exp_t e;
    model_start();
    do_start(8'd2);
    tick();
    tick();
    n_tests++;
    if ({busy, in_ready, out_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL stall_wait: got busy=%b in_ready=%b out_valid=%b, want 1 1 0", busy, in_ready, out_valid);
    end
    drive_beat(16'h0100, 1'b1);
    tick();
    drive_beat(16'h0100, 1'b0);
    model_push();
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      prod     = 32'h0000_7FFF;
      if (i == 2) begin
        start = 1'b1;
        len   = 8'd3;
      end
      n_tests++;
      if ({in_ready, out_valid, acc, zero, neg, overflow} !== {2'b01, e}) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: got rdy=%b ov=%b acc=%h z=%b n=%b ovf=%b, want 0 1 acc=%h z=%b n=%b ovf=%b",
                 i, in_ready, out_valid, acc, zero, neg, overflow, e.acc, e.zero, e.neg, e.ovf);
      end
      tick();
      start = 1'b0;
    end
    in_valid  = 1'b0;
    start     = 1'b1;
    len       = 8'd1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if ({busy, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_start_on_handshake: got busy=%b out_valid=%b, want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit   ok;
    exp_t e;
    model_start();
    do_start(8'd3);
    drive_beat(16'h0100, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, out_valid, busy, acc, neg, overflow, zero} !== {3'b000, 32'h0, 3'b001}) begin
      n_fail++;
      $display("FAIL midreset_values: got rdy=%b ov=%b busy=%b acc=%h neg=%b ovf=%b zero=%b, want 0 0 0 00000000 0 0 1",
               in_ready, out_valid, busy, acc, neg, overflow, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_reduction('{16'h0080, 16'h0000, 16'h0000, 16'h0000}, 1);
    wait_out(ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || {acc, zero, neg, overflow} !== e) begin
      n_fail++;
      $display("FAIL midreset_restart: got acc=%h z=%b n=%b ovf=%b (valid=%b), want acc=%h z=%b n=%b ovf=%b",
               acc, zero, neg, overflow, ok, e.acc, e.zero, e.neg, e.ovf);
    end
    finish_out();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_back_to_back();
    test_saturation();
    test_zero_result();
    test_len_zero();
    test_stall_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
